// File: rtl/vga_scan_driver.sv
// vga_scan_driver
// Scan-side master of the pixel-layer interface. Generates raster coordinates
// for the layer blocks, composites the layer reply over the background colour,
// and drives the VGA pins with sync, blanking and colour all registered together
// one pixel behind the coordinates. Also emits a per-frame tick at vblank start.

`default_nettype none

module vga_scan_driver #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        layer_hit,
  input  logic [11:0] layer_rgb,
  input  logic [11:0] bg_rgb,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        pix_tick,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [11:0] rgb,
  output logic        frame_tick
);

  // Raster geometry
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Divider width; a divide-by-one still needs a one-bit counter
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Sized compare constants so every comparison is 10-bit against 10-bit
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]       H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0]       V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0]       V_VIS_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0]       HS_BEGIN   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]       HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]       VS_BEGIN   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]       VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  // State
  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_cnt_q, h_cnt_d;
  logic [9:0]       v_cnt_q, v_cnt_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             frame_tick_q, frame_tick_d;

  // Per-pixel decode of the current coordinates
  logic             tick;
  logic             act;
  logic             hs_n;
  logic             vs_n;
  logic [11:0]      pix;
  logic             vblank_start;

  // Pixel-rate strobe from the clock divider
  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + 1'b1;
  end

  // Horizontal/vertical counters; both wrap so they never leave range
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (tick) begin
      if (h_cnt_q >= H_LAST) begin
        h_cnt_d = '0;
        if (v_cnt_q >= V_LAST) begin
          v_cnt_d = '0;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  // Visibility, sync windows and composite colour for the current pixel
  always_comb begin
    act          = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    hs_n         = !((h_cnt_q >= HS_BEGIN) && (h_cnt_q < HS_END));
    vs_n         = !((v_cnt_q >= VS_BEGIN) && (v_cnt_q < VS_END));
    vblank_start = (h_cnt_q == H_LAST) && (v_cnt_q == V_VIS_LAST);
    // Blanking selects a constant first, so undriven layer inputs outside
    // the visible area can never reach the pins.
    pix = 12'h000;
    if (act) begin
      if (layer_hit) begin
        pix = layer_rgb;
      end else begin
        pix = bg_rgb;
      end
    end
  end

  // Pin-side registers: all four load on the same tick so they stay aligned
  always_comb begin
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    video_on_d   = video_on_q;
    rgb_d        = rgb_q;
    frame_tick_d = 1'b0;
    if (tick) begin
      hsync_d      = hs_n;
      vsync_d      = vs_n;
      video_on_d   = act;
      rgb_d        = pix;
      frame_tick_d = vblank_start;
    end
  end

  // State registers with asynchronous active-low reset back to (0,0)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q        <= '0;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      video_on_q   <= 1'b0;
      rgb_q        <= 12'h000;
      frame_tick_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      video_on_q   <= video_on_d;
      rgb_q        <= rgb_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign x          = h_cnt_q;
  assign y          = v_cnt_q;
  assign pix_tick   = tick;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign video_on   = video_on_q;
  assign rgb        = rgb_q;
  assign frame_tick = frame_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_scan_driver.sv
// Testbench for vga_scan_driver. Two instances share clock, reset and layer
// inputs: one with the full 640x480 timing, one with a tiny raster so that
// several whole frames fit in a short run. A reference model derives every
// expected output from the number of clock edges since reset release.
module tb_vga_scan_driver;

  // Small raster: 25 x 17 pixels, 1700 clks per frame
  localparam int S_HA = 16, S_HF = 2, S_HS = 4, S_HB = 3;
  localparam int S_VA = 10, S_VF = 2, S_VS = 2, S_VB = 3;

  logic        clk;
  logic        reset_n;
  logic        layer_hit;
  logic [11:0] layer_rgb;
  logic [11:0] bg_rgb;

  logic [9:0]  x_a   [2];
  logic [9:0]  y_a   [2];
  logic        pt_a  [2];
  logic        hs_a  [2];
  logic        vs_a  [2];
  logic        vo_a  [2];
  logic [11:0] rgb_a [2];
  logic        ft_a  [2];

  // Geometry of each instance (0 = full, 1 = small)
  int g_div [2] = '{4, 4};
  int g_ha  [2] = '{640, S_HA};
  int g_hf  [2] = '{16,  S_HF};
  int g_hs  [2] = '{96,  S_HS};
  int g_hb  [2] = '{48,  S_HB};
  int g_va  [2] = '{480, S_VA};
  int g_vf  [2] = '{10,  S_VF};
  int g_vs  [2] = '{2,   S_VS};
  int g_vb  [2] = '{33,  S_VB};

  vga_scan_driver dut_full (
    .clk(clk), .reset_n(reset_n), .layer_hit(layer_hit), .layer_rgb(layer_rgb),
    .bg_rgb(bg_rgb), .x(x_a[0]), .y(y_a[0]), .pix_tick(pt_a[0]), .hsync(hs_a[0]),
    .vsync(vs_a[0]), .video_on(vo_a[0]), .rgb(rgb_a[0]), .frame_tick(ft_a[0])
  );

  vga_scan_driver #(
    .CLK_DIV(4), .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
  ) dut_small (
    .clk(clk), .reset_n(reset_n), .layer_hit(layer_hit), .layer_rgb(layer_rgb),
    .bg_rgb(bg_rgb), .x(x_a[1]), .y(y_a[1]), .pix_tick(pt_a[1]), .hsync(hs_a[1]),
    .vsync(vs_a[1]), .video_on(vo_a[1]), .rgb(rgb_a[1]), .frame_tick(ft_a[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: edges since release and the expected registered outputs
  int          c;
  logic        exp_hs  [2], exp_vs  [2], exp_vo  [2], exp_ft  [2];
  logic [11:0] exp_rgb [2];
  logic        nxt_hs  [2], nxt_vs  [2], nxt_vo  [2], nxt_ft  [2];
  logic [11:0] nxt_rgb [2];

  // Run-2 measurements
  logic measure;
  int   full_hs_low, full_hs_first, full_y1_first, full_ft_cnt;
  int   small_vs_low;
  int   small_ft_c [$];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s c=%0d got=%0h exp=%0h", tag, c, got, exp);
    end
  endtask

  function automatic int h_tot(int d);
    return g_ha[d] + g_hf[d] + g_hs[d] + g_hb[d];
  endfunction

  function automatic int v_tot(int d);
    return g_va[d] + g_vf[d] + g_vs[d] + g_vb[d];
  endfunction

  task automatic model_reset();
    c = 0;
    for (int d = 0; d < 2; d++) begin
      exp_hs[d] = 1'b1; exp_vs[d] = 1'b1; exp_vo[d] = 1'b0;
      exp_rgb[d] = 12'h000; exp_ft[d] = 1'b0;
    end
  endtask

  // Expected pin values for the pixel that the coming tick will register
  task automatic plan_pixel();
    for (int d = 0; d < 2; d++) begin
      int p, px, py;
      logic act;
      p   = c / g_div[d];
      px  = p % h_tot(d);
      py  = (p / h_tot(d)) % v_tot(d);
      act = (px < g_ha[d]) && (py < g_va[d]);
      nxt_vo[d]  = act;
      nxt_hs[d]  = !((px >= g_ha[d] + g_hf[d]) && (px < g_ha[d] + g_hf[d] + g_hs[d]));
      nxt_vs[d]  = !((py >= g_va[d] + g_vf[d]) && (py < g_va[d] + g_vf[d] + g_vs[d]));
      nxt_rgb[d] = !act ? 12'h000 : (layer_hit ? layer_rgb : bg_rgb);
      nxt_ft[d]  = (px == h_tot(d) - 1) && (py == g_va[d] - 1);
    end
  endtask

  task automatic advance();
    c++;
    for (int d = 0; d < 2; d++) begin
      if (c % g_div[d] == 0) begin
        exp_hs[d] = nxt_hs[d]; exp_vs[d] = nxt_vs[d]; exp_vo[d] = nxt_vo[d];
        exp_rgb[d] = nxt_rgb[d]; exp_ft[d] = nxt_ft[d];
      end else begin
        exp_ft[d] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      int p;
      p = c / g_div[d];
      check_value($sformatf("x[%0d]", d), 32'(x_a[d]), 32'(p % h_tot(d)));
      check_value($sformatf("y[%0d]", d), 32'(y_a[d]), 32'((p / h_tot(d)) % v_tot(d)));
      check_value($sformatf("pix_tick[%0d]", d), 32'(pt_a[d]), 32'(c % g_div[d] == g_div[d] - 1));
      check_value($sformatf("hsync[%0d]", d), 32'(hs_a[d]), 32'(exp_hs[d]));
      check_value($sformatf("vsync[%0d]", d), 32'(vs_a[d]), 32'(exp_vs[d]));
      check_value($sformatf("video_on[%0d]", d), 32'(vo_a[d]), 32'(exp_vo[d]));
      check_value($sformatf("rgb[%0d]", d), 32'(rgb_a[d]), 32'(exp_rgb[d]));
      check_value($sformatf("frame_tick[%0d]", d), 32'(ft_a[d]), 32'(exp_ft[d]));
    end
  endtask

  task automatic drive_random();
    int sel;
    layer_hit = 1'($urandom_range(0, 1));
    sel = $urandom_range(0, 2);
    layer_rgb = (sel == 0) ? 12'hF00 : (sel == 1) ? 12'hFFF : 12'($urandom);
    bg_rgb    = ($urandom_range(0, 1) == 1) ? 12'h0AF : 12'($urandom);
  endtask

  // Free-run n clocks from a negedge, checking every clock
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive_random();
      if (c % g_div[0] == g_div[0] - 1) plan_pixel();
      @(posedge clk);
      advance();
      @(negedge clk);
      check_all();
      if (measure) begin
        if (hs_a[0] == 1'b0) begin
          full_hs_low++;
          if (full_hs_first < 0) full_hs_first = c;
        end
        if (y_a[0] == 10'd1 && full_y1_first < 0) full_y1_first = c;
        if (ft_a[0] == 1'b1) full_ft_cnt++;
        if (vs_a[1] == 1'b0) small_vs_low++;
        if (ft_a[1] == 1'b1) small_ft_c.push_back(c);
      end
    end
  endtask

  initial begin
    measure = 1'b0;
    full_hs_low = 0; full_hs_first = -1; full_y1_first = -1; full_ft_cnt = 0;
    small_vs_low = 0;
    layer_hit = 1'b0; layer_rgb = 12'h000; bg_rgb = 12'h000;
    model_reset();

    // Power-on reset
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all();
    reset_n = 1'b1;
    $display("phase 1: free-run 1202 clks after reset");
    run(1202);

    // Asynchronous reset mid-line (full x=300) and mid-frame (small)
    @(posedge clk);
    #3 reset_n = 1'b0;
    model_reset();
    #1 check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    reset_n = 1'b1;

    $display("phase 2: free-run 7000 clks with measurements");
    measure = 1'b1;
    run(7000);
    measure = 1'b0;

    // Line and frame timing aggregates
    check_value("full_hs_low_clks", 32'(full_hs_low), 32'(2 * 96 * 4));
    check_value("full_hs_first_fall", 32'(full_hs_first), 32'((656 + 1) * 4));
    check_value("full_line_period", 32'(full_y1_first), 32'(800 * 4));
    check_value("full_frame_ticks", 32'(full_ft_cnt), 32'(0));
    check_value("small_vs_low_clks", 32'(small_vs_low), 32'(4 * S_VS * 25 * 4));
    check_value("small_ft_count", 32'(small_ft_c.size()), 32'(4));
    if (small_ft_c.size() >= 2) begin
      check_value("small_ft_first", 32'(small_ft_c[0]), 32'(S_VA * 25 * 4));
      check_value("small_ft_gap", 32'(small_ft_c[1] - small_ft_c[0]), 32'(25 * 17 * 4));
    end else begin
      check_value("small_ft_gap", 32'(0), 32'(25 * 17 * 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
